// File: rtl/perm_round_sched.sv
// Round scheduler for an iterated permutation shared by two requesters.
// Sequences five one-hot step enables per round and guards each step with a watchdog.
module perm_round_sched #(
    parameter int NUM_ROUNDS   = 24,
    parameter int STEP_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic [4:0] step_en,
    input  logic [4:0] step_done,
    output logic [4:0] round_idx,
    output logic       busy,
    output logic       err,
    input  logic       clr_err
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_GRANT  = 4'd1,
        S_COLP   = 4'd2,
        S_ROT    = 4'd3,
        S_PERM   = 4'd4,
        S_REVAL  = 4'd5,
        S_ADDRC  = 4'd6,
        S_NEXT   = 4'd7,
        S_FINISH = 4'd8,
        S_FAULT  = 4'd9
    } state_t;

    localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS - 1);
    // The step state is occupied for at most STEP_TIMEOUT cycles before faulting.
    localparam logic [7:0] WD_LIMIT   = 8'(STEP_TIMEOUT - 1);

    state_t      state_r;
    state_t      state_nx;
    state_t      next_step_s;
    logic        owner_r;
    logic        ptr_r;
    logic [4:0]  round_r;
    logic [7:0]  wdog_r;
    logic        arb_owner_s;
    logic [4:0]  step_sel_s;
    logic        is_step_s;
    logic        step_hit_s;
    logic        start_s;
    logic [1:0]  owner_oh_s;

    // Round-robin pick between the two requesters
    always_comb begin
        arb_owner_s = ptr_r;
        if (req == 2'b01) begin
            arb_owner_s = 1'b0;
        end else if (req == 2'b10) begin
            arb_owner_s = 1'b1;
        end else begin
            arb_owner_s = ptr_r;
        end
    end

    // Decode the active step and its successor
    always_comb begin
        step_sel_s  = 5'b00000;
        next_step_s = S_IDLE;
        case (state_r)
            S_COLP:  begin step_sel_s = 5'b00001; next_step_s = S_ROT;   end
            S_ROT:   begin step_sel_s = 5'b00010; next_step_s = S_PERM;  end
            S_PERM:  begin step_sel_s = 5'b00100; next_step_s = S_REVAL; end
            S_REVAL: begin step_sel_s = 5'b01000; next_step_s = S_ADDRC; end
            S_ADDRC: begin step_sel_s = 5'b10000; next_step_s = S_NEXT;  end
            default: begin step_sel_s = 5'b00000; next_step_s = S_IDLE;  end
        endcase
    end

    assign is_step_s  = |step_sel_s;
    assign step_hit_s = |(step_sel_s & step_done);
    assign start_s    = (state_r == S_IDLE) && (|req);
    assign owner_oh_s = owner_r ? 2'b10 : 2'b01;

    // Next-state logic
    always_comb begin
        state_nx = state_r;
        case (state_r)
            S_IDLE: begin
                if (|req) state_nx = S_GRANT;
                else      state_nx = S_IDLE;
            end
            S_GRANT: state_nx = S_COLP;
            S_COLP, S_ROT, S_PERM, S_REVAL, S_ADDRC: begin
                if (step_hit_s)             state_nx = next_step_s;
                else if (wdog_r == WD_LIMIT) state_nx = S_FAULT;
                else                        state_nx = state_r;
            end
            S_NEXT: begin
                if (round_r == LAST_ROUND) state_nx = S_FINISH;
                else                       state_nx = S_COLP;
            end
            S_FINISH: state_nx = S_IDLE;
            S_FAULT: begin
                if (clr_err) state_nx = S_IDLE;
                else         state_nx = S_FAULT;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State, ownership, priority, round and watchdog registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            owner_r <= 1'b0;
            ptr_r   <= 1'b0;
            round_r <= 5'd0;
            wdog_r  <= 8'd0;
        end else begin
            state_r <= state_nx;
            if (start_s) owner_r <= arb_owner_s;
            if (state_r == S_FINISH) ptr_r <= ~owner_r;
            if (start_s) begin
                round_r <= 5'd0;
            end else if ((state_r == S_NEXT) && (round_r != LAST_ROUND)) begin
                round_r <= round_r + 5'd1;
            end
            if (state_nx != state_r) begin
                wdog_r <= 8'd0;
            end else if (is_step_s) begin
                wdog_r <= wdog_r + 8'd1;
            end
        end
    end

    // Outputs decoded purely from the registers
    always_comb begin
        gnt  = 2'b00;
        done = 2'b00;
        busy = 1'b1;
        err  = 1'b0;
        case (state_r)
            S_IDLE:   busy = 1'b0;
            S_FAULT:  begin busy = 1'b0; err = 1'b1; end
            S_FINISH: begin gnt = owner_oh_s; done = owner_oh_s; end
            S_GRANT, S_COLP, S_ROT, S_PERM, S_REVAL, S_ADDRC, S_NEXT: gnt = owner_oh_s;
            default:  busy = 1'b0;
        endcase
    end

    assign step_en   = step_sel_s;
    assign round_idx = round_r;

endmodule

// File: tb/tb_perm_round_sched.sv
// Randomized self-checking bench for perm_round_sched; expected traces are
// generated per operation from the round/step schedule with plain loops.
module tb_perm_round_sched;

    localparam int NR = 24;
    localparam int TO = 255;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [1:0] gnt;
    logic [1:0] done;
    logic [4:0] step_en;
    logic [4:0] step_done;
    logic [4:0] round_idx;
    logic       busy;
    logic       err;
    logic       clr_err;

    int total = 0;
    int bad   = 0;
    int cycle_no = 0;
    int t_gnt = 0;
    int meas_lat = -1;
    bit gnt_seen = 1'b0;
    logic       ptr_m = 1'b0;
    logic [4:0] rnd_m = 5'd0;

    perm_round_sched dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .done(done),
        .step_en(step_en), .step_done(step_done), .round_idx(round_idx),
        .busy(busy), .err(err), .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cycle_no);
        end
    endtask

    function automatic logic [4:0] rsd();
        return 5'($urandom_range(0, 31));
    endfunction

    function automatic logic [1:0] rreq();
        return 2'($urandom_range(0, 3));
    endfunction

    // One clock: check outputs of the current state, then drive inputs for the next edge
    task automatic cyc(input logic [1:0] e_gnt, input logic [4:0] e_en, input logic [4:0] e_rnd,
                       input logic [1:0] e_done, input logic e_busy, input logic e_err,
                       input logic [1:0] d_req, input logic [4:0] d_sd, input logic d_clr);
        @(negedge clk);
        cycle_no++;
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("step_en", 32'(step_en), 32'(e_en));
        chk("round_idx", 32'(round_idx), 32'(e_rnd));
        chk("done", 32'(done), 32'(e_done));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("err", 32'(err), 32'(e_err));
        if (gnt == 2'b00) gnt_seen = 1'b0;
        else if (!gnt_seen) begin
            gnt_seen = 1'b1;
            t_gnt = cycle_no;
        end
        if (done != 2'b00) meas_lat = cycle_no - t_gnt;
        req       = d_req;
        step_done = d_sd;
        clr_err   = d_clr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(2'b00, 5'd0, rnd_m, 2'b00, 1'b0, 1'b0, 2'b00, rsd(), 1'b0);
    endtask

    task automatic do_reset(input logic [1:0] oh);
        @(posedge clk);
        #1;
        chk("pre_rst_gnt", 32'(gnt), 32'(oh));
        rst = 1'b1;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_step_en", 32'(step_en), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_round", 32'(round_idx), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        req = 2'b00;
        step_done = 5'd0;
        ptr_m = 1'b0;
        rnd_m = 5'd0;
        gnt_seen = 1'b0;
    endtask

    // One whole operation predicted from the schedule rules
    task automatic run_op(input logic [1:0] pat, input bit zw, input int dly_r,
                          input int fault_r, input int fault_s, input int rst_r);
        logic       own;
        logic [1:0] oh;
        logic [4:0] sb;
        int d;
        int extra;
        own = (pat == 2'b01) ? 1'b0 : (pat == 2'b10) ? 1'b1 : ptr_m;
        oh  = own ? 2'b10 : 2'b01;
        extra = 0;
        meas_lat = -1;
        cyc(2'b00, 5'd0, rnd_m, 2'b00, 1'b0, 1'b0, pat, rsd(), 1'b0);
        rnd_m = 5'd0;
        cyc(oh, 5'd0, rnd_m, 2'b00, 1'b1, 1'b0, rreq(), rsd(), 1'b0);
        for (int r = 0; r < NR; r++) begin
            rnd_m = 5'(r);
            for (int s = 0; s < 5; s++) begin
                sb = 5'b00001 << s;
                if (r == rst_r && s == 2) begin
                    do_reset(oh);
                    return;
                end
                if (r == fault_r && s == fault_s) begin
                    for (int i = 0; i < TO; i++)
                        cyc(oh, sb, rnd_m, 2'b00, 1'b1, 1'b0, rreq(), rsd() & ~sb, 1'b0);
                    for (int i = 0; i < 4; i++)
                        cyc(2'b00, 5'd0, rnd_m, 2'b00, 1'b0, 1'b1, rreq(), rsd(), 1'b0);
                    cyc(2'b00, 5'd0, rnd_m, 2'b00, 1'b0, 1'b1, rreq(), rsd(), 1'b1);
                    return;
                end
                if (r == dly_r && s == 2) d = 3;
                else if (zw) d = 0;
                else d = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
                for (int i = 0; i < d; i++)
                    cyc(oh, sb, rnd_m, 2'b00, 1'b1, 1'b0, rreq(), rsd() & ~sb, 1'b0);
                cyc(oh, sb, rnd_m, 2'b00, 1'b1, 1'b0, rreq(), rsd() | sb, 1'b0);
                extra += d;
            end
            cyc(oh, 5'd0, rnd_m, 2'b00, 1'b1, 1'b0, rreq(), rsd(), 1'b0);
        end
        cyc(oh, 5'd0, rnd_m, oh, 1'b1, 1'b0, rreq(), rsd(), 1'b0);
        ptr_m = ~own;
        chk("latency", 32'(meas_lat), 32'(6 * NR + 1 + extra));
    endtask

    initial begin
        rst = 1'b1;
        req = 2'b00;
        step_done = 5'd0;
        clr_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_step_en", 32'(step_en), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_round", 32'(round_idx), 32'd0);
        rst = 1'b0;
        idle(1);

        run_op(2'b01, 1'b1, -1, -1, -1, -1);
        for (int k = 0; k < 3; k++) run_op(2'b11, 1'b1, -1, -1, -1, -1);
        run_op(2'b10, 1'b1, 5, -1, -1, -1);

        for (int k = 0; k < 6; k++) begin
            idle($urandom_range(0, 2));
            run_op(2'($urandom_range(1, 3)), 1'b0, -1, -1, -1, -1);
        end

        idle(1);
        run_op(2'($urandom_range(1, 3)), 1'b0, -1, $urandom_range(0, NR - 1), 3, -1);
        idle(2);
        run_op(2'b11, 1'b0, -1, -1, -1, -1);

        idle(1);
        run_op(2'b01, 1'b0, -1, -1, -1, -1);
        run_op(2'b11, 1'b0, -1, -1, -1, 10);
        idle(1);
        run_op(2'b11, 1'b0, -1, -1, -1, -1);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/perm_round_sched.md
PERM_ROUND_SCHED -- requirements
Module: perm_round_sched

Parameters
REQ-001 The block SHALL have parameter NUM_ROUNDS, default 24, giving the number of rounds per permutation (legal range 1..31).
REQ-002 The block SHALL have parameter STEP_TIMEOUT, default 255, giving the maximum cycles a step may wait for its done (legal range 1..255).

Interface
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  2  per-requester permutation request, level.
REQ-006 gnt  output  2  one-hot grant to the owning requester; selects that requester's state memory.
REQ-007 done  output  2  one-cycle completion pulse to the owner.
REQ-008 step_en  output  5  one-hot step enable: [0] colParity, [1] rotate, [2] permute, [3] revalute, [4] addRC.
REQ-009 step_done  input  5  per-step completion, same bit order as step_en.
REQ-010 round_idx  output  5  current round number, used by addRC for constant selection.
REQ-011 busy  output  1  high in every state except IDLE and FAULT.
REQ-012 err  output  1  high while in FAULT.
REQ-013 clr_err  input  1  returns the block from FAULT to IDLE.

Function
REQ-014 The block SHALL implement the states IDLE, GRANT, COLP, ROT, PERM, REVAL, ADDRC, NEXT, FINISH and FAULT, with all outputs decoded from the state and counter registers only.
REQ-015 IDLE: if any req bit is high, go to GRANT; otherwise stay in IDLE.
REQ-016 Arbitration SHALL be round-robin using a 1-bit priority pointer: a single request wins; on a tie, the requester named by the pointer wins.
REQ-017 On FINISH, the pointer SHALL be set to the non-owner.
REQ-018 GRANT: hold round_idx = 0, then go to COLP.
REQ-019 Owner gnt SHALL be high from GRANT through FINISH inclusive, and low in all other states.
REQ-020 Each step state SHALL assert only its own step_en bit.
REQ-021 A step state SHALL advance on the first cycle its step_done bit is high, sampled in the same cycle as step_en (zero-wait allowed).
REQ-022 Step sequence SHALL be COLP -> ROT -> PERM -> REVAL -> ADDRC -> NEXT.
REQ-023 step_done bits not matching the current step, and all step_done bits outside step states, SHALL be ignored.
REQ-024 NEXT: if round_idx == NUM_ROUNDS-1, go to FINISH; otherwise increment round_idx and go to COLP.
REQ-025 FINISH: done[owner] = 1 for exactly one cycle, then go to IDLE.
REQ-026 A new request may be granted in the cycle after FINISH.
REQ-027 Latency with zero-wait steps SHALL be 6*NUM_ROUNDS+1 cycles from the gnt rising edge to done; this is 145 cycles for NUM_ROUNDS = 24.
REQ-028 A watchdog counter SHALL clear on every step-state entry and increment each cycle the step waits.
REQ-029 If the watchdog reaches STEP_TIMEOUT without the step's done, the block SHALL go to FAULT: gnt = 0, step_en = 0, no done pulse.
REQ-030 FAULT SHALL be held until clr_err = 1, then go to IDLE; the priority pointer is unchanged.
REQ-031 Deassertion of req by the owner during an operation SHALL be ignored; the operation completes.
REQ-032 A request from the non-owner during an operation SHALL wait and be arbitrated only in IDLE.
REQ-033 round_idx SHALL hold its last value outside GRANT..NEXT.

Reset
REQ-034 rst = 1 SHALL immediately force IDLE, pointer = 0, round_idx = 0, watchdog = 0, and gnt, done, step_en, busy and err all 0, including when rst is asserted mid-operation.
REQ-035 The first cycle after reset release SHALL behave as IDLE.

Verification
REQ-036 req = 01, all step_done tied high -> gnt = 01, step_en cycles one-hot 5 steps x 24 rounds, round_idx 0..23, done = 01 exactly 145 cycles after gnt rises.
REQ-037 req = 11 held high -> grants alternate 01, 10, 01; no gap longer than 1 IDLE cycle between operations.
REQ-038 step_done[2] delayed 3 cycles in round 5 -> step_en = 00100 held 4 cycles, total latency 148 cycles, round_idx = 5 throughout that step.
REQ-039 step_done[3] never asserted -> err = 1 after 255 waiting cycles, gnt = 00, no done pulse; clr_err pulse -> IDLE, busy = 0.
REQ-040 rst pulsed at round 10 -> all outputs 0 asynchronously; a new req afterwards restarts at round_idx = 0 with pointer = 0.
REQ-041 Wrong-step step_done pulses and owner req dropping mid-operation -> sequence and latency unchanged, done still delivered.
